// File: rtl/router_pkg.sv
// Shared definitions for the router datapath: byte width and the header address field.
package router_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_W   = 2;

  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t ADDR_INVALID = 2'b11;

  // Destination address carried in the low bits of the header byte.
  function automatic addr_t addr_of(input logic [DATA_W-1:0] b);
    return b[ADDR_LSB +: ADDR_W];
  endfunction

endpackage

// File: rtl/router_parity_acc.sv
// Running XOR parity of a packet, with a clear, an xor-enable and a compare
// against the captured trailing parity byte.
module router_parity_acc
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              i_clear,
  input  logic              i_xor_en,
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_cmp,
  output logic              o_mismatch
);

  logic [DATA_W-1:0] r_parity;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_parity <= '0;
    end else if (i_clear) begin
      r_parity <= '0;
    end else if (i_xor_en) begin
      r_parity <= r_parity ^ i_data;
    end
  end

  assign o_mismatch = (r_parity != i_cmp);

endmodule

// File: rtl/router_reg.sv
// Per-port byte register and parity checker between the router FSM and the
// output FIFOs; every update is driven by the one-hot FSM state strobes.
module router_reg
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              resetn,
  input  logic              packet_valid,
  input  logic [DATA_W-1:0] datain,
  input  logic              fifo_full,
  input  logic              detect_add,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic              parity_done,
  output logic              low_packet_valid,
  output logic              err,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] r_hdr;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_pkt_parity;
  logic [DATA_W-1:0] r_dout;
  logic              r_parity_done;
  logic              r_low_pv;
  logic              r_err;

  logic              w_hdr_load;
  logic              w_cap_ld;
  logic              w_cap_laf;
  logic              w_acc_en;
  logic [DATA_W-1:0] w_acc_data;
  logic              w_mismatch;

  // Address 2'b11 is not a valid destination, so such a header is not latched.
  assign w_hdr_load = detect_add && packet_valid && (addr_of(datain) != ADDR_INVALID);

  // Parity byte arrives either directly in load, or parked in hold_reg while full.
  assign w_cap_ld   = ld_state && !fifo_full && !packet_valid;
  assign w_cap_laf  = laf_state && r_low_pv && !r_parity_done;

  assign w_acc_en   = lfd_state || (ld_state && packet_valid && !full_state);
  assign w_acc_data = lfd_state ? r_hdr : datain;

  router_parity_acc u_parity_acc (
    .clk        (clk),
    .resetn     (resetn),
    .i_clear    (detect_add),
    .i_xor_en   (w_acc_en),
    .i_data     (w_acc_data),
    .i_cmp      (r_pkt_parity),
    .o_mismatch (w_mismatch)
  );

  // NOTE: reset is synchronous, so it sits inside the clocked branch and
  // takes priority over every other rule on the same edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hdr         <= '0;
      r_hold        <= '0;
      r_pkt_parity  <= '0;
      r_dout        <= '0;
      r_parity_done <= 1'b0;
      r_low_pv      <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      if (w_hdr_load) r_hdr <= datain;

      if (lfd_state)                   r_dout <= r_hdr;
      else if (ld_state && !fifo_full) r_dout <= datain;
      else if (ld_state && fifo_full)  r_hold <= datain;
      else if (laf_state)              r_dout <= r_hold;

      if (w_cap_ld) begin
        r_pkt_parity  <= datain;
        r_parity_done <= 1'b1;
      end else if (w_cap_laf) begin
        r_pkt_parity  <= r_hold;
        r_parity_done <= 1'b1;
      end else if (detect_add) begin
        r_parity_done <= 1'b0;
      end

      if (ld_state && !packet_valid) r_low_pv <= 1'b1;
      else if (rst_int_reg)          r_low_pv <= 1'b0;

      if (rst_int_reg && r_parity_done)    r_err <= w_mismatch;
      else if (detect_add && packet_valid) r_err <= 1'b0;
    end
  end

  assign dout             = r_dout;
  assign parity_done      = r_parity_done;
  assign low_packet_valid = r_low_pv;
  assign err              = r_err;

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: FSM strobe sequences with hand-computed results.
module tb_router_reg;

  logic       clk = 1'b0;
  logic       resetn;
  logic       packet_valid;
  logic [7:0] datain;
  logic       fifo_full;
  logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic       parity_done, low_packet_valid, err;
  logic [7:0] dout;

  int n_pass  = 0;
  int n_total = 0;

  // Strobe encodings: {detect_add, lfd, ld, laf, full, rst_int_reg}
  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_DA   = 6'b100000;
  localparam logic [5:0] S_LFD  = 6'b010000;
  localparam logic [5:0] S_LD   = 6'b001000;
  localparam logic [5:0] S_LAF  = 6'b000100;
  localparam logic [5:0] S_FULL = 6'b000010;
  localparam logic [5:0] S_RST  = 6'b000001;

  router_reg dut (
    .clk              (clk),
    .resetn           (resetn),
    .packet_valid     (packet_valid),
    .datain           (datain),
    .fifo_full        (fifo_full),
    .detect_add       (detect_add),
    .lfd_state        (lfd_state),
    .ld_state         (ld_state),
    .laf_state        (laf_state),
    .full_state       (full_state),
    .rst_int_reg      (rst_int_reg),
    .parity_done      (parity_done),
    .low_packet_valid (low_packet_valid),
    .err              (err),
    .dout             (dout)
  );

  always #5 clk = ~clk;

  // Apply one cycle of stimulus, clock it, and settle 1 time unit past the edge.
  task automatic cyc(input logic [5:0] st, input logic pv, input logic [7:0] d, input logic ff);
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = st;
    packet_valid = pv;
    datain       = d;
    fifo_full    = ff;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cyc(S_NONE, 1'b0, 8'h00, 1'b0);
    cyc(S_NONE, 1'b0, 8'h00, 1'b0);
    n_total++; if (dout !== 8'h00) $display("FAIL reset_dout got=%h exp=00", dout); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL reset_err got=%b exp=0", err); else n_pass++;
    n_total++; if (parity_done !== 1'b0) $display("FAIL reset_parity_done got=%b exp=0", parity_done); else n_pass++;
    n_total++; if (low_packet_valid !== 1'b0) $display("FAIL reset_lpv got=%b exp=0", low_packet_valid); else n_pass++;
    resetn = 1'b1;
  endtask

  // Header 05, payload 11 22, parity byte par; expected err = (par != 36).
  task automatic run_packet(input string tag, input logic [7:0] par, input logic exp_err);
    cyc(S_DA, 1'b1, 8'h05, 1'b0);
    n_total++; if (parity_done !== 1'b0) $display("FAIL %s_pd_clear got=%b exp=0", tag, parity_done); else n_pass++;
    cyc(S_LFD, 1'b1, 8'h11, 1'b0);
    n_total++; if (dout !== 8'h05) $display("FAIL %s_dout_hdr got=%h exp=05", tag, dout); else n_pass++;
    cyc(S_LD, 1'b1, 8'h11, 1'b0);
    n_total++; if (dout !== 8'h11) $display("FAIL %s_dout_b1 got=%h exp=11", tag, dout); else n_pass++;
    cyc(S_LD, 1'b1, 8'h22, 1'b0);
    n_total++; if (dout !== 8'h22) $display("FAIL %s_dout_b2 got=%h exp=22", tag, dout); else n_pass++;
    cyc(S_LD, 1'b0, par, 1'b0);
    n_total++; if (dout !== par) $display("FAIL %s_dout_par got=%h exp=%h", tag, dout, par); else n_pass++;
    n_total++; if (parity_done !== 1'b1) $display("FAIL %s_pd got=%b exp=1", tag, parity_done); else n_pass++;
    n_total++; if (low_packet_valid !== 1'b1) $display("FAIL %s_lpv got=%b exp=1", tag, low_packet_valid); else n_pass++;
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    n_total++; if (err !== exp_err) $display("FAIL %s_err got=%b exp=%b", tag, err, exp_err); else n_pass++;
    n_total++; if (low_packet_valid !== 1'b0) $display("FAIL %s_lpv_clr got=%b exp=0", tag, low_packet_valid); else n_pass++;
    cyc(S_NONE, 1'b0, 8'h00, 1'b0);
    n_total++; if (err !== exp_err) $display("FAIL %s_err_hold got=%b exp=%b", tag, err, exp_err); else n_pass++;
  endtask

  task automatic test_good_packet();
    run_packet("good", 8'h36, 1'b0);
  endtask

  task automatic test_bad_parity();
    run_packet("bad", 8'h37, 1'b1);
    cyc(S_DA, 1'b0, 8'h06, 1'b0);
    n_total++; if (err !== 1'b1) $display("FAIL bad_err_no_pv got=%b exp=1", err); else n_pass++;
    cyc(S_DA, 1'b1, 8'h06, 1'b0);
    n_total++; if (err !== 1'b0) $display("FAIL bad_err_clear got=%b exp=0", err); else n_pass++;
  endtask

  // Header 06 latched above; A5 parked while the FIFO is full.
  task automatic test_fifo_full();
    cyc(S_LFD, 1'b1, 8'hA5, 1'b0);
    n_total++; if (dout !== 8'h06) $display("FAIL full_dout_hdr got=%h exp=06", dout); else n_pass++;
    cyc(S_LD, 1'b1, 8'hA5, 1'b1);
    n_total++; if (dout !== 8'h06) $display("FAIL full_dout_hold got=%h exp=06", dout); else n_pass++;
    cyc(S_FULL, 1'b1, 8'hA5, 1'b1);
    n_total++; if (dout !== 8'h06) $display("FAIL full_dout_fs got=%h exp=06", dout); else n_pass++;
    cyc(S_LAF, 1'b1, 8'h00, 1'b0);
    n_total++; if (dout !== 8'hA5) $display("FAIL full_dout_laf got=%h exp=a5", dout); else n_pass++;
    n_total++; if (parity_done !== 1'b0) $display("FAIL full_pd_laf got=%b exp=0", parity_done); else n_pass++;
    cyc(S_LD, 1'b0, 8'hA3, 1'b0);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    n_total++; if (err !== 1'b0) $display("FAIL full_err got=%b exp=0", err); else n_pass++;
  endtask

  task automatic test_invalid_addr();
    cyc(S_DA, 1'b1, 8'h03, 1'b0);
    cyc(S_LFD, 1'b1, 8'h00, 1'b0);
    n_total++; if (dout !== 8'h06) $display("FAIL inv_dout_hdr got=%h exp=06", dout); else n_pass++;
    cyc(S_LD, 1'b0, 8'h06, 1'b0);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    n_total++; if (err !== 1'b0) $display("FAIL inv_err got=%b exp=0", err); else n_pass++;
  endtask

  // Header 09, payload 44 -> parity 4D, which arrives while the FIFO is full.
  task automatic test_laf_parity();
    cyc(S_DA, 1'b1, 8'h09, 1'b0);
    cyc(S_LFD, 1'b1, 8'h44, 1'b0);
    cyc(S_LD, 1'b1, 8'h44, 1'b0);
    n_total++; if (dout !== 8'h44) $display("FAIL laf_dout_b1 got=%h exp=44", dout); else n_pass++;
    cyc(S_LD, 1'b0, 8'h4D, 1'b1);
    n_total++; if (dout !== 8'h44) $display("FAIL laf_dout_hold got=%h exp=44", dout); else n_pass++;
    n_total++; if (low_packet_valid !== 1'b1) $display("FAIL laf_lpv got=%b exp=1", low_packet_valid); else n_pass++;
    n_total++; if (parity_done !== 1'b0) $display("FAIL laf_pd_early got=%b exp=0", parity_done); else n_pass++;
    cyc(S_FULL, 1'b0, 8'h00, 1'b1);
    cyc(S_LAF, 1'b0, 8'h00, 1'b0);
    n_total++; if (dout !== 8'h4D) $display("FAIL laf_dout_par got=%h exp=4d", dout); else n_pass++;
    n_total++; if (parity_done !== 1'b1) $display("FAIL laf_pd got=%b exp=1", parity_done); else n_pass++;
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    n_total++; if (err !== 1'b0) $display("FAIL laf_err got=%b exp=0", err); else n_pass++;
    n_total++; if (low_packet_valid !== 1'b0) $display("FAIL laf_lpv_clr got=%b exp=0", low_packet_valid); else n_pass++;
  endtask

  task automatic test_mid_reset();
    cyc(S_DA, 1'b1, 8'h05, 1'b0);
    cyc(S_LFD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b1, 8'h11, 1'b0);
    cyc(S_LD, 1'b0, 8'h00, 1'b0);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    n_total++; if (err !== 1'b1) $display("FAIL mid_err_pre got=%b exp=1", err); else n_pass++;
    cyc(S_LD, 1'b0, 8'h7E, 1'b0);
    resetn = 1'b0;
    cyc(S_LD, 1'b1, 8'h22, 1'b0);
    n_total++; if (dout !== 8'h00) $display("FAIL mid_dout got=%h exp=00", dout); else n_pass++;
    n_total++; if (err !== 1'b0) $display("FAIL mid_err got=%b exp=0", err); else n_pass++;
    n_total++; if (parity_done !== 1'b0) $display("FAIL mid_pd got=%b exp=0", parity_done); else n_pass++;
    n_total++; if (low_packet_valid !== 1'b0) $display("FAIL mid_lpv got=%b exp=0", low_packet_valid); else n_pass++;
    resetn = 1'b1;
    // Header 0A, payload 0F -> parity 05.
    cyc(S_DA, 1'b1, 8'h0A, 1'b0);
    cyc(S_LFD, 1'b1, 8'h0F, 1'b0);
    n_total++; if (dout !== 8'h0A) $display("FAIL post_dout_hdr got=%h exp=0a", dout); else n_pass++;
    cyc(S_LD, 1'b1, 8'h0F, 1'b0);
    cyc(S_LD, 1'b0, 8'h05, 1'b0);
    cyc(S_RST, 1'b0, 8'h00, 1'b0);
    n_total++; if (err !== 1'b0) $display("FAIL post_err got=%b exp=0", err); else n_pass++;
  endtask

  initial begin
    resetn = 1'b0;
    {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg} = S_NONE;
    packet_valid = 1'b0;
    datain       = 8'h00;
    fifo_full    = 1'b0;
    test_reset();
    test_good_packet();
    test_bad_parity();
    test_fifo_full();
    test_invalid_addr();
    test_laf_parity();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
